apb_cfg_master: RTL and testbench

- APB initiator that drives register writes and reads into the TPU configuration slave on behalf of a host-side sequencer or testbench controller.
- Accepts commands (write flag, address, write data) into a small FIFO and serialises them as APB transfers.
- Returns one response per command: read data or write acknowledge, plus a timeout flag.
- Sits between the host command path and the configuration register block on the same PCLK domain.

---
 rtl/apb_cfg_master.sv | 191 +++++++++++++++++++
 tb/tb_apb_cfg_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_master.sv
// APB initiator for the configuration slave. Host commands are queued in a
// small FIFO and issued one at a time as APB transfers. Each transfer takes the
// path IDLE -> SETUP -> ACCESS -> GAP. Every command returns exactly one
// response, and a transfer that never sees PREADY is aborted with a timeout.
//
// Ports:
//   PCLK, PRESET            clock; synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (write flag, addr, wdata)
//   rsp_valid               one-cycle pulse per completed command, with
//                           rsp_write/rsp_rdata/rsp_timeout held until the next
//   busy, fifo_count        activity and queue occupancy
//   PADDR..PREADY           APB initiator interface (all outputs registered)
module apb_cfg_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  output logic                          rsp_write,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PWRITE,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;
  localparam int TmoW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StGap} state_e;

  // Command FIFO
  logic                  r_mem_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_wdata [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wptr, r_rptr;
  logic [CntW-1:0]       r_count;
  logic                  w_push, w_pop;

  // Transfer state
  state_e                r_state, w_state_d;
  logic [TmoW-1:0]       r_tcnt, w_tcnt_d;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_d;
  logic                  r_pwrite, w_pwrite_d;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_d;
  logic                  r_psel, w_psel_d;
  logic                  r_penable, w_penable_d;
  logic                  r_rsp_valid, w_rsp_valid_d;
  logic                  r_rsp_write, w_rsp_write_d;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_d;
  logic                  r_rsp_timeout, w_rsp_timeout_d;

  // A full FIFO refuses a push even when a pop happens at the same edge,
  // because cmd_ready depends only on the registered count.
  assign cmd_ready  = (r_count != FullCnt);
  assign w_push     = cmd_valid && cmd_ready;
  assign fifo_count = r_count;
  assign busy       = (r_state != StIdle) || (r_count != '0);

  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem_write[r_wptr] <= cmd_write;
      r_mem_addr[r_wptr]  <= cmd_addr;
      r_mem_wdata[r_wptr] <= cmd_wdata;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= StIdle;
      r_tcnt        <= '0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_tcnt        <= w_tcnt_d;
      r_paddr       <= w_paddr_d;
      r_pwrite      <= w_pwrite_d;
      r_pwdata      <= w_pwdata_d;
      r_psel        <= w_psel_d;
      r_penable     <= w_penable_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_write   <= w_rsp_write_d;
      r_rsp_rdata   <= w_rsp_rdata_d;
      r_rsp_timeout <= w_rsp_timeout_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_tcnt_d        = r_tcnt;
    w_paddr_d       = r_paddr;
    w_pwrite_d      = r_pwrite;
    w_pwdata_d      = r_pwdata;
    w_rsp_write_d   = r_rsp_write;
    w_rsp_rdata_d   = r_rsp_rdata;
    w_rsp_timeout_d = r_rsp_timeout;
    w_pop           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_pop      = 1'b1;
          w_paddr_d  = r_mem_addr[r_rptr];
          w_pwrite_d = r_mem_write[r_rptr];
          w_pwdata_d = r_mem_wdata[r_rptr];
          w_state_d  = StSetup;
        end
      end
      StSetup: begin
        w_tcnt_d  = '0;
        w_state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          w_rsp_write_d   = r_pwrite;
          w_rsp_rdata_d   = r_pwrite ? '0 : PRDATA;
          w_rsp_timeout_d = 1'b0;
          w_state_d       = StGap;
        end else if (r_tcnt == TmoLast) begin
          // This was the TIMEOUT-th ACCESS cycle without PREADY.
          w_rsp_write_d   = r_pwrite;
          w_rsp_rdata_d   = '0;
          w_rsp_timeout_d = 1'b1;
          w_state_d       = StGap;
        end else begin
          w_tcnt_d = r_tcnt + TmoW'(1);
        end
      end
      StGap: begin
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Registered APB controls and the response strobe follow the next state.
    w_psel_d      = (w_state_d == StSetup) || (w_state_d == StAccess);
    w_penable_d   = (w_state_d == StAccess);
    w_rsp_valid_d = (w_state_d == StGap);
  end

  assign PADDR       = r_paddr;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_rsp_write;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master. A register-file slave answers on the 2nd ACCESS
// cycle, except at HoleAddr, which never answers. A command-level model predicts
// each response when its command is accepted. A negedge compare process checks
// the responses and the APB phase sequence on every cycle. Directed literal
// checks cover the corner cases.
module tb_apb_cfg_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int TO = 16;
  localparam int CW = $clog2(FD) + 1;
  localparam logic [AW-1:0] HoleAddr = 8'hEE;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_write, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE, PREADY;
  logic [DW-1:0] PWDATA, PRDATA;

  always #5 PCLK = ~PCLK;

  apb_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy), .fifo_count(fifo_count),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- Slave: register file, ready on 2nd ACCESS cycle ---------
  logic [DW-1:0] smem [256];
  bit            smem_init = 1'b0;
  int unsigned   acc_cnt = 0;

  assign PREADY = PSEL && PENABLE && (PADDR != HoleAddr) && (acc_cnt == 1);
  assign PRDATA = (PADDR == HoleAddr) ? 32'hDEAD_BEEF : smem[PADDR];

  always @(posedge PCLK) begin
    if (!smem_init) begin
      foreach (smem[i]) smem[i] <= '0;
      smem_init <= 1'b1;
    end else if (!PRESET && PSEL && PENABLE && PREADY && PWRITE) begin
      smem[PADDR] <= PWDATA;
    end
    if (PRESET || !(PSEL && PENABLE) || PREADY) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  // ---------------- Model: predict the response of each accepted command ----
  typedef struct {
    logic          w;
    logic [DW-1:0] rdata;
    logic          to;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] mmem [256];
  bit            mmem_init = 1'b0;

  always @(posedge PCLK) begin
    exp_t e;
    if (!mmem_init) begin
      foreach (mmem[i]) mmem[i] <= '0;
      mmem_init <= 1'b1;
    end
    if (PRESET) begin
      exp_q.delete();
    end else if (cmd_valid && cmd_ready) begin
      e.w     = cmd_write;
      e.to    = (cmd_addr == HoleAddr);
      e.rdata = (cmd_write || e.to) ? '0 : mmem[cmd_addr];
      if (cmd_write && !e.to) mmem[cmd_addr] <= cmd_wdata;
      exp_q.push_back(e);
    end
  end

  // ---------------- Compare process ----------------------------------------
  logic          rst_seen = 1'b1;
  logic          p_setup = 1'b0, p_access = 1'b0, p_end = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic          p_write = 1'b0;
  logic [DW-1:0] p_wdata = '0;
  int            acc_len = 0;
  int            last_acc_len = 0;
  int            rsp_cnt = 0;
  bit            saw_full = 1'b0;

  always @(posedge PCLK) rst_seen <= PRESET;

  always @(negedge PCLK) begin
    int   cur_len;
    logic end_now;
    exp_t e;
    if (rst_seen) begin
      p_setup  <= 1'b0;
      p_access <= 1'b0;
      p_end    <= 1'b0;
      acc_len  <= 0;
    end else begin
      if (p_setup || (p_access && !p_end)) begin
        check("access_follows", {PSEL, PENABLE}, 2'b11);
        check("paddr_stable", PADDR, p_addr);
        check("pwrite_stable", PWRITE, p_write);
        check("pwdata_stable", PWDATA, p_wdata);
      end else if (p_end) begin
        check("gap_psel_low", {PSEL, PENABLE}, 2'b00);
      end else begin
        check("no_access_without_setup", PENABLE, 1'b0);
      end
      check("rsp_valid_timing", rsp_valid, p_end);
      if (rsp_valid) begin
        rsp_cnt++;
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_write", rsp_write, e.w);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_timeout", rsp_timeout, e.to);
        end
      end
      check("cmd_ready_rule", cmd_ready, fifo_count != CW'(FD));
      if (fifo_count == CW'(FD)) saw_full = 1'b1;
      cur_len = (PSEL && PENABLE) ? ((p_access && !p_end) ? acc_len + 1 : 1) : 0;
      end_now = PSEL && PENABLE && (PREADY || cur_len == TO);
      if (end_now) last_acc_len = cur_len;
      p_setup  <= PSEL && !PENABLE;
      p_access <= PSEL && PENABLE;
      p_end    <= end_now;
      p_addr   <= PADDR;
      p_write  <= PWRITE;
      p_wdata  <= PWDATA;
      acc_len  <= cur_len;
    end
  end

  // ---------------- Directed stimulus --------------------------------------
  // Leaves cmd_valid high after the accepting edge; callers drop it.
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = cmd_ready;
      @(posedge PCLK);
    end
    check("push_accepted", acc, 1'b1);
  endtask

  task automatic idle_cmd();
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge PCLK);
      seen = rsp_valid;
    end
    check("rsp_seen", seen, 1'b1);
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge PCLK);
      idle = !busy;
    end
    check("drain_idle", idle, 1'b1);
  endtask

  initial begin
    int base;
    logic seen;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    check("rst_psel", {PSEL, PENABLE}, 2'b00);
    check("rst_paddr", PADDR, 0);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_timeout}, 3'b000);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_ready_busy", {cmd_ready, busy}, 2'b10);
    check("rst_count", fifo_count, 0);

    // Write 9 to address 0; cycle-by-cycle latency.
    push(1'b1, 8'h00, 32'h0000_0009);
    idle_cmd();
    check("lat_idle_pop", {PSEL, busy, 32'(fifo_count)}, {1'b0, 1'b1, 32'd1});
    @(negedge PCLK);
    check("lat_setup", {PSEL, PENABLE}, 2'b10);
    @(negedge PCLK);
    check("lat_access1", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    check("lat_access2", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    check("lat_rsp", {rsp_valid, rsp_write, rsp_timeout}, 3'b110);
    check("lat_rsp_rdata", rsp_rdata, 0);
    check("write_acc_len", last_acc_len, 2);
    check("slave_reg0", smem[0], 32'h9);
    drain();

    // Read it back.
    push(1'b0, 8'h00, 32'hFFFF_FFFF);
    idle_cmd();
    wait_rsp();
    check("readback", {rsp_write, rsp_rdata}, {1'b0, 32'h0000_0009});
    drain();

    // Five back-to-back commands through a depth-4 FIFO.
    base = rsp_cnt;
    saw_full = 1'b0;
    push(1'b1, 8'h01, 32'h11);
    push(1'b1, 8'h02, 32'h22);
    push(1'b1, 8'h03, 32'h33);
    push(1'b0, 8'h01, 32'h0);
    push(1'b0, 8'h03, 32'h0);
    idle_cmd();
    drain();
    check("five_saw_full", saw_full, 1'b1);
    check("five_rsp_count", rsp_cnt - base, 5);
    check("five_last_rdata", rsp_rdata, 32'h33);

    // Timeout on the hole, then a normal write.
    push(1'b0, HoleAddr, 32'h0);
    push(1'b1, 8'h10, 32'hA5A5);
    idle_cmd();
    wait_rsp();
    check("to_flag_rdata", {rsp_timeout, rsp_rdata}, {1'b1, 32'h0});
    check("to_acc_len", last_acc_len, TO);
    wait_rsp();
    check("after_to", {rsp_timeout, rsp_write}, 2'b01);
    check("after_to_len", last_acc_len, 2);
    drain();
    check("slave_reg10", smem[8'h10], 32'hA5A5);

    // Reset during ACCESS with two commands queued.
    base = rsp_cnt;
    push(1'b0, HoleAddr, 32'h0);
    push(1'b0, HoleAddr, 32'h0);
    push(1'b0, HoleAddr, 32'h0);
    idle_cmd();
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      seen = PSEL && PENABLE && (fifo_count == CW'(2));
      if (!seen) @(negedge PCLK);
    end
    check("rst_mid_reached", seen, 1'b1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("rst_mid_apb", {PSEL, PENABLE}, 2'b00);
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_ready_busy", {cmd_ready, busy, rsp_valid}, 3'b100);
    repeat (25) @(negedge PCLK);
    check("rst_mid_no_rsp", rsp_cnt - base, 0);

    // Push rejected at the edge where a full FIFO pops.
    base = rsp_cnt;
    push(1'b0, HoleAddr, 32'h0);
    push(1'b1, 8'h20, 32'h1);
    push(1'b1, 8'h21, 32'h2);
    push(1'b1, 8'h22, 32'h3);
    push(1'b1, 8'h23, 32'h4);
    @(negedge PCLK);
    cmd_write = 1'b1;
    cmd_addr  = 8'h24;
    cmd_wdata = 32'h5;
    check("full_count", fifo_count, 4);
    wait_rsp();
    check("full_at_gap", {cmd_ready, 32'(fifo_count)}, {1'b0, 32'd4});
    @(negedge PCLK);
    check("full_at_idle", fifo_count, 4);
    @(negedge PCLK);
    check("pop_with_rejected_push", fifo_count, 3);
    cmd_valid = 1'b0;
    drain();
    check("full_rsp_count", rsp_cnt - base, 5);
    check("rejected_not_written", smem[8'h24], 32'h0);
    check("last_accepted_written", smem[8'h23], 32'h4);
    check("model_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
